// File: rtl/dzcpu_uop_sequencer_pkg.sv
// Shared definitions for the dzcpu micro-program sequencer: flow-field codes,
// the CB-redispatch op code, FSM state encoding and default widths.
package dzcpu_uop_pkg;

  localparam int unsigned DEF_UOP_W  = 13;
  localparam int unsigned DEF_FLOW_W = 4;
  localparam int unsigned DEF_UPC_W  = 8;
  localparam int unsigned OP_W       = 5;

  // Op field occupies the top OP_W bits of the uop body.
  localparam logic [OP_W-1:0] OP_JCB = 5'h1F;

  typedef enum logic [DEF_FLOW_W-1:0] {
    FL_OP           = 4'd0,
    FL_INC          = 4'd1,
    FL_UPDATE_FLAGS = 4'd2,
    FL_EOF          = 4'd3,
    FL_INC_EOF      = 4'd4,
    FL_EOF_FU       = 4'd5,
    FL_INC_EOF_FU   = 4'd6,
    FL_INC_EOF_Z    = 4'd7,
    FL_INC_EOF_NZ   = 4'd8
  } flow_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXEC      = 3'd2,
    ST_CB_WAIT   = 3'd3,
    ST_CB_DECODE = 3'd4
  } state_e;

endpackage

// File: rtl/dzcpu_uop_sequencer_flow_decode.sv
// Combinational decode of a uop flow-control field plus the Z flag into the
// per-cycle execution strobes.
module dzcpu_uop_flow_decode
  import dzcpu_uop_pkg::*;
(
  input  logic [DEF_FLOW_W-1:0] flow_i,
  input  logic                  flag_z_i,
  output logic                  valid_o,
  output logic                  pcinc_o,
  output logic                  updflags_o,
  output logic                  eof_o
);

  flow_e flow;
  assign flow = flow_e'(flow_i);

  always_comb begin
    valid_o    = 1'b0;
    pcinc_o    = 1'b0;
    updflags_o = 1'b0;
    eof_o      = 1'b0;
    unique case (flow)
      FL_OP: valid_o = 1'b1;
      FL_INC: begin
        valid_o = 1'b1;
        pcinc_o = 1'b1;
      end
      FL_UPDATE_FLAGS: begin
        valid_o    = 1'b1;
        updflags_o = 1'b1;
      end
      FL_EOF: begin
        valid_o = 1'b1;
        eof_o   = 1'b1;
      end
      FL_INC_EOF: begin
        valid_o = 1'b1;
        pcinc_o = 1'b1;
        eof_o   = 1'b1;
      end
      FL_EOF_FU: begin
        valid_o    = 1'b1;
        eof_o      = 1'b1;
        updflags_o = 1'b1;
      end
      FL_INC_EOF_FU: begin
        valid_o    = 1'b1;
        pcinc_o    = 1'b1;
        eof_o      = 1'b1;
        updflags_o = 1'b1;
      end
      // Conditional exit: taken exit drops the body; not taken behaves as inc.
      FL_INC_EOF_Z: begin
        pcinc_o = 1'b1;
        eof_o   = flag_z_i;
        valid_o = !flag_z_i;
      end
      FL_INC_EOF_NZ: begin
        pcinc_o = 1'b1;
        eof_o   = !flag_z_i;
        valid_o = flag_z_i;
      end
      default: valid_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/dzcpu_uop_sequencer.sv
// dzcpu micro-program sequencer: latches opcode/CB bytes for the flow LUTs,
// loads the micro-PC and steps the uop ROM, emitting datapath strobes.
module dzcpu_uop_sequencer
  import dzcpu_uop_pkg::*;
#(
  parameter int unsigned UOP_W  = DEF_UOP_W,
  parameter int unsigned FLOW_W = DEF_FLOW_W,
  parameter int unsigned UPC_W  = DEF_UPC_W
) (
  input  logic                    iClock,
  input  logic                    iReset,
  input  logic [7:0]              iMemData,
  input  logic                    iMemValid,
  input  logic                    iStall,
  input  logic                    iFlagZ,
  input  logic [UPC_W-1:0]        iFlowIdx,
  input  logic [UPC_W-1:0]        iCbFlowIdx,
  input  logic [UOP_W-1:0]        iUop,
  output logic [7:0]              oMop,
  output logic [7:0]              oCbMop,
  output logic [UPC_W-1:0]        oUopAddr,
  output logic [UOP_W-FLOW_W-1:0] oUopBody,
  output logic                    oUopValid,
  output logic                    oPcInc,
  output logic                    oUpdateFlags,
  output logic                    oEof,
  output logic                    oFault
);

  localparam int unsigned BODY_W = UOP_W - FLOW_W;

  state_e           state_q;
  logic [7:0]       mop_q;
  logic [7:0]       cbmop_q;
  logic [UPC_W-1:0] upc_q;
  logic             fault_q;

  logic [BODY_W-1:0] body;
  logic [OP_W-1:0]   op_field;
  logic              dec_valid, dec_pcinc, dec_updflags, dec_eof;
  logic              exec_go, is_jcb, at_end, wrap_fault;

  assign body     = iUop[BODY_W-1:0];
  assign op_field = body[BODY_W-1 -: OP_W];

  dzcpu_uop_flow_decode u_flow_decode (
    .flow_i     (DEF_FLOW_W'(iUop[UOP_W-1 -: FLOW_W])),
    .flag_z_i   (iFlagZ),
    .valid_o    (dec_valid),
    .pcinc_o    (dec_pcinc),
    .updflags_o (dec_updflags),
    .eof_o      (dec_eof)
  );

  always_comb begin
    exec_go      = (state_q == ST_EXEC) && !iStall && !iReset;
    is_jcb       = (op_field == OP_JCB);
    at_end       = (upc_q == '1);
    wrap_fault   = exec_go && !is_jcb && !dec_eof && at_end;
    oUopValid    = 1'b0;
    oPcInc       = 1'b0;
    oUpdateFlags = 1'b0;
    oEof         = 1'b0;
    if (exec_go) begin
      if (is_jcb) begin
        oPcInc = dec_pcinc;
      end else begin
        oUopValid    = dec_valid;
        oPcInc       = dec_pcinc;
        oUpdateFlags = dec_updflags;
        oEof         = dec_eof;
      end
    end
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_q <= ST_IDLE;
      mop_q   <= '0;
      cbmop_q <= '0;
      upc_q   <= '0;
      fault_q <= 1'b0;
    end else if (!iStall) begin
      unique case (state_q)
        ST_IDLE: begin
          if (iMemValid) begin
            mop_q   <= iMemData;
            state_q <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          upc_q   <= iFlowIdx;
          state_q <= ST_EXEC;
        end
        ST_EXEC: begin
          if (is_jcb) begin
            state_q <= ST_CB_WAIT;
          end else if (dec_eof) begin
            state_q <= ST_IDLE;
          end else if (wrap_fault) begin
            // micro-PC is left at the last ROM slot so the faulting flow is visible
            fault_q <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            upc_q <= upc_q + UPC_W'(1);
          end
        end
        ST_CB_WAIT: begin
          if (iMemValid) begin
            cbmop_q <= iMemData;
            state_q <= ST_CB_DECODE;
          end
        end
        ST_CB_DECODE: begin
          upc_q   <= iCbFlowIdx;
          state_q <= ST_EXEC;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign oMop     = mop_q;
  assign oCbMop   = cbmop_q;
  assign oUopAddr = upc_q;
  assign oUopBody = body;
  assign oFault   = fault_q;

endmodule

// File: tb/tb_dzcpu_uop_sequencer.sv
// Directed bench for dzcpu_uop_sequencer with behavioural LUT/ROM models.
module tb_dzcpu_uop_sequencer;
  import dzcpu_uop_pkg::*;

  logic        clk = 1'b0;
  logic        rst, mv, stall, z;
  logic [7:0]  md;
  logic [7:0]  flow_idx, cb_flow_idx;
  logic [12:0] uop;
  logic [7:0]  mop, cbmop, addr;
  logic [8:0]  body;
  logic        valid, pcinc, updf, eof, fault;

  logic [12:0] rom [256];
  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  dzcpu_uop_sequencer #(.UOP_W(13), .FLOW_W(4), .UPC_W(8)) dut (
    .iClock(clk), .iReset(rst), .iMemData(md), .iMemValid(mv), .iStall(stall),
    .iFlagZ(z), .iFlowIdx(flow_idx), .iCbFlowIdx(cb_flow_idx), .iUop(uop),
    .oMop(mop), .oCbMop(cbmop), .oUopAddr(addr), .oUopBody(body),
    .oUopValid(valid), .oPcInc(pcinc), .oUpdateFlags(updf), .oEof(eof), .oFault(fault)
  );

  always_comb begin
    case (mop)
      8'h31:   flow_idx = 8'd1;
      8'h20:   flow_idx = 8'd17;
      8'hCB:   flow_idx = 8'd13;
      8'hCD:   flow_idx = 8'd50;
      8'hD3:   flow_idx = 8'd250;
      default: flow_idx = 8'd0;
    endcase
    cb_flow_idx = (cbmop == 8'h7C) ? 8'd16 : 8'd0;
    uop = rom[addr];
  end

  function automatic logic [12:0] mk(input flow_e f, input logic [7:0] a);
    return {f, 1'b0, a[3:0], a[7:4]};
  endfunction

  typedef struct {
    logic       rst, mv, stall, z;
    logic [7:0] md;
    logic [7:0] addr;
    logic [3:0] vpue;
    logic [7:0] mop, cb;
    logic       fault;
  } vec_t;

  vec_t tbl[$];
  logic [7:0] tm, tc;
  logic       tf;

  // Queue one vector; expected mop/cb/fault come from the fill-time trackers.
  task automatic add(input logic r, input logic v, input logic [7:0] d, input logic s,
                     input logic zz, input logic [7:0] a, input logic [3:0] st);
    vec_t e;
    e.rst = r; e.mv = v; e.md = d; e.stall = s; e.z = zz;
    e.addr = a; e.vpue = st; e.mop = tm; e.cb = tc; e.fault = tf;
    tbl.push_back(e);
  endtask

  task automatic chk(input string name, input int unsigned row, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h want %h", name, row, act, exp);
    end
  endtask

  task automatic step(input vec_t e, input int unsigned row);
    @(negedge clk);
    rst = e.rst; mv = e.mv; md = e.md; stall = e.stall; z = e.z;
    #1;
    chk("uop_addr", row, 16'(addr), 16'(e.addr));
    chk("strobes", row, 16'({valid, pcinc, updf, eof}), 16'(e.vpue));
    chk("mop", row, 16'(mop), 16'(e.mop));
    chk("cb_mop", row, 16'(cbmop), 16'(e.cb));
    chk("fault", row, 16'(fault), 16'(e.fault));
    chk("body", row, 16'(body), 16'(rom[e.addr][8:0]));
  endtask

  task automatic run_tbl(input int unsigned base);
    for (int unsigned i = 0; i < tbl.size(); i++) step(tbl[i], base + i);
    tbl.delete();
  endtask

  initial begin
    for (int unsigned i = 0; i < 256; i++) rom[i] = mk(FL_EOF, 8'(i));
    rom[0]  = mk(FL_INC_EOF, 8'd0);
    rom[1]  = mk(FL_INC, 8'd1);
    rom[2]  = mk(FL_INC, 8'd2);
    rom[3]  = mk(FL_OP, 8'd3);
    rom[4]  = mk(FL_INC_EOF, 8'd4);
    rom[13] = mk(FL_OP, 8'd13);
    rom[14] = mk(FL_INC, 8'd14);
    rom[15] = {FL_INC, OP_JCB, 4'h0};
    rom[16] = mk(FL_EOF_FU, 8'd16);
    rom[17] = mk(FL_INC, 8'd17);
    rom[18] = mk(FL_OP, 8'd18);
    rom[19] = mk(FL_INC_EOF_Z, 8'd19);
    rom[20] = mk(FL_OP, 8'd20);
    rom[21] = mk(FL_OP, 8'd21);
    rom[22] = mk(FL_EOF, 8'd22);
    rom[50] = mk(FL_INC, 8'd50);
    rom[51] = mk(FL_INC, 8'd51);
    for (int unsigned i = 52; i < 57; i++) rom[i] = mk(FL_OP, 8'(i));
    rom[57] = mk(FL_EOF, 8'd57);
    for (int unsigned i = 250; i < 256; i++) rom[i] = mk(FL_OP, 8'(i));

    rst = 1'b1; mv = 1'b0; md = '0; stall = 1'b0; z = 1'b0;
    repeat (2) @(posedge clk);

    tm = 8'h00; tc = 8'h00; tf = 1'b0;
    // reset state, then flow index 0 (generic one-byte flow)
    add(0,0,8'h00,0,0, 8'd0, 4'b0000);
    add(0,1,8'h00,0,0, 8'd0, 4'b0000);
    add(0,0,8'h00,0,0, 8'd0, 4'b0000);
    add(0,0,8'h00,0,0, 8'd0, 4'b1101);
    // LDSPnn
    add(0,1,8'h31,0,0, 8'd0, 4'b0000); tm = 8'h31;
    add(0,0,8'h00,0,0, 8'd0, 4'b0000);
    add(0,0,8'h00,0,0, 8'd1, 4'b1100);
    add(0,0,8'h00,0,0, 8'd2, 4'b1100);
    add(0,0,8'h00,0,0, 8'd3, 4'b1000);
    add(0,0,8'h00,0,0, 8'd4, 4'b1101);
    // JRNZn with Z=1: exits at 19 with body suppressed
    add(0,1,8'h20,0,0, 8'd4, 4'b0000); tm = 8'h20;
    add(0,0,8'h00,0,0, 8'd4, 4'b0000);
    add(0,0,8'h00,0,1, 8'd17, 4'b1100);
    add(0,0,8'h00,0,1, 8'd18, 4'b1000);
    add(0,0,8'h00,0,1, 8'd19, 4'b0101);
    // JRNZn with Z=0: continues to 22
    add(0,1,8'h20,0,0, 8'd19, 4'b0000);
    add(0,0,8'h00,0,0, 8'd19, 4'b0000);
    add(0,0,8'h00,0,0, 8'd17, 4'b1100);
    add(0,0,8'h00,0,0, 8'd18, 4'b1000);
    add(0,0,8'h00,0,0, 8'd19, 4'b1100);
    add(0,0,8'h00,0,0, 8'd20, 4'b1000);
    add(0,0,8'h00,0,0, 8'd21, 4'b1000);
    add(0,0,8'h00,0,0, 8'd22, 4'b1001);
    // CB 0x7C redispatch
    add(0,0,8'h00,0,0, 8'd22, 4'b0000);
    add(0,1,8'hCB,0,0, 8'd22, 4'b0000); tm = 8'hCB;
    add(0,0,8'h00,0,0, 8'd22, 4'b0000);
    add(0,0,8'h00,0,0, 8'd13, 4'b1000);
    add(0,0,8'h00,0,0, 8'd14, 4'b1100);
    add(0,0,8'h00,0,0, 8'd15, 4'b0100);
    add(0,0,8'h00,0,0, 8'd15, 4'b0000);
    add(0,1,8'h7C,0,0, 8'd15, 4'b0000); tc = 8'h7C;
    add(0,0,8'h00,0,0, 8'd15, 4'b0000);
    add(0,0,8'h00,0,0, 8'd16, 4'b1011);
    // CALLnn with a 3-cycle stall at 52 and a stall colliding with eof at 57
    add(0,1,8'hCD,0,0, 8'd16, 4'b0000); tm = 8'hCD;
    add(0,0,8'h00,0,0, 8'd16, 4'b0000);
    add(0,0,8'h00,0,0, 8'd50, 4'b1100);
    add(0,0,8'h00,0,0, 8'd51, 4'b1100);
    add(0,0,8'h00,1,0, 8'd52, 4'b0000);
    add(0,0,8'h00,1,0, 8'd52, 4'b0000);
    add(0,0,8'h00,1,0, 8'd52, 4'b0000);
    add(0,0,8'h00,0,0, 8'd52, 4'b1000);
    add(0,0,8'h00,0,0, 8'd53, 4'b1000);
    add(0,0,8'h00,0,0, 8'd54, 4'b1000);
    add(0,0,8'h00,0,0, 8'd55, 4'b1000);
    add(0,0,8'h00,0,0, 8'd56, 4'b1000);
    add(0,0,8'h00,1,0, 8'd57, 4'b0000);
    add(0,0,8'h00,0,0, 8'd57, 4'b1001);
    // stall beats iMemValid in IDLE: opcode must not latch
    add(0,1,8'h31,1,0, 8'd57, 4'b0000);
    add(0,0,8'h00,0,0, 8'd57, 4'b0000);
    run_tbl(0);

    // Hand sequence: reset mid-CALLnn at uPC 55
    add(0,1,8'hCD,0,0, 8'd57, 4'b0000);
    add(0,0,8'h00,0,0, 8'd57, 4'b0000);
    add(0,0,8'h00,0,0, 8'd50, 4'b1100);
    add(0,0,8'h00,0,0, 8'd51, 4'b1100);
    for (int unsigned a = 52; a < 55; a++) add(0,0,8'h00,0,0, 8'(a), 4'b1000);
    add(1,0,8'h00,0,0, 8'd55, 4'b0000);
    tm = 8'h00; tc = 8'h00;
    add(0,0,8'h00,0,0, 8'd0, 4'b0000);
    add(0,0,8'h00,0,0, 8'd0, 4'b0000);
    run_tbl(100);

    // Hand sequence: micro-PC runs off the ROM end, fault is sticky until reset
    add(0,1,8'hD3,0,0, 8'd0, 4'b0000); tm = 8'hD3;
    add(0,0,8'h00,0,0, 8'd0, 4'b0000);
    for (int unsigned a = 250; a < 256; a++) add(0,0,8'h00,0,0, 8'(a), 4'b1000);
    tf = 1'b1;
    add(0,0,8'h00,0,0, 8'd255, 4'b0000);
    add(0,0,8'h00,0,0, 8'd255, 4'b0000);
    add(0,1,8'h00,0,0, 8'd255, 4'b0000); tm = 8'h00;
    add(0,0,8'h00,0,0, 8'd255, 4'b0000);
    add(0,0,8'h00,0,0, 8'd0, 4'b1101);
    add(0,0,8'h00,0,0, 8'd0, 4'b0000);
    add(1,0,8'h00,0,0, 8'd0, 4'b0000);
    tf = 1'b0;
    add(0,0,8'h00,0,0, 8'd0, 4'b0000);
    run_tbl(200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
